// File: rtl/toy_mem_rr_arbiter.sv
// Two-port round-robin arbiter in front of a single-cycle memory.
// Each port has a small response FSM (IDLE/WAIT/HOLD) so that a stalled
// response on one port never blocks grants to the other port.
module toy_mem_rr_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic                    p0_req_vld,
    output logic                    p0_req_rdy,
    input  logic [ADDR_WIDTH-1:0]   p0_req_addr,
    input  logic                    p0_req_wr_en,
    input  logic [DATA_WIDTH-1:0]   p0_req_wr_data,
    input  logic [DATA_WIDTH/8-1:0] p0_req_wr_byte_en,
    output logic                    p0_rsp_vld,
    input  logic                    p0_rsp_rdy,
    output logic [DATA_WIDTH-1:0]   p0_rsp_data,

    input  logic                    p1_req_vld,
    output logic                    p1_req_rdy,
    input  logic [ADDR_WIDTH-1:0]   p1_req_addr,
    input  logic                    p1_req_wr_en,
    input  logic [DATA_WIDTH-1:0]   p1_req_wr_data,
    input  logic [DATA_WIDTH/8-1:0] p1_req_wr_byte_en,
    output logic                    p1_rsp_vld,
    input  logic                    p1_rsp_rdy,
    output logic [DATA_WIDTH-1:0]   p1_rsp_data,

    output logic                    mem_en,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic                    mem_wr_en,
    output logic [DATA_WIDTH-1:0]   mem_wr_data,
    output logic [DATA_WIDTH/8-1:0] mem_wr_byte_en,
    input  logic [DATA_WIDTH-1:0]   mem_rd_data
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } rsp_state_t;

    logic [1:0]                 req_vld;
    logic [1:0]                 rsp_rdy;
    logic [1:0]                 path_free;
    logic [1:0]                 eligible;
    logic [1:0]                 grant;
    logic [1:0]                 rsp_vld;
    logic [1:0][DATA_WIDTH-1:0] rsp_data;
    logic                       ptr_reg;
    logic                       ptr_next;
    logic                       accept;
    logic                       win;

    assign req_vld = {p1_req_vld, p0_req_vld};
    assign rsp_rdy = {p1_rsp_rdy, p0_rsp_rdy};

    // Pick at most one eligible port; the pointer only breaks ties.
    // Reset gates the grant so req_rdy/mem_en stay low while rst_n is low.
    always_comb begin
        eligible = req_vld & path_free;
        grant    = 2'b00;
        if (rst_n) begin
            if (eligible == 2'b11) begin
                grant = ptr_reg ? 2'b10 : 2'b01;
            end else begin
                grant = eligible;
            end
        end
    end

    assign accept = |grant;
    assign win    = grant[1];

    // After any grant the pointer favours the port that did not win.
    always_comb begin
        ptr_next = ptr_reg;
        if (accept) begin
            ptr_next = ~win;
        end
    end

    // Priority pointer register, port 0 favoured out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg <= 1'b0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

    // Memory command is the winning port's request, issued in the grant cycle.
    always_comb begin
        mem_en         = accept;
        mem_addr       = win ? p1_req_addr       : p0_req_addr;
        mem_wr_en      = accept & (win ? p1_req_wr_en : p0_req_wr_en);
        mem_wr_data    = win ? p1_req_wr_data    : p0_req_wr_data;
        mem_wr_byte_en = win ? p1_req_wr_byte_en : p0_req_wr_byte_en;
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rsp
            rsp_state_t            state_reg;
            rsp_state_t            state_next;
            logic [DATA_WIDTH-1:0] hold_reg;
            logic [DATA_WIDTH-1:0] hold_next;
            logic                  vld_out;
            logic                  free_out;
            logic [DATA_WIDTH-1:0] data_out;

            // Response state register.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_reg <= ST_IDLE;
                end else begin
                    state_reg <= state_next;
                end
            end

            // Next state: a drained slot can be refilled in the same cycle.
            always_comb begin
                state_next = state_reg;
                case (state_reg)
                    ST_IDLE: begin
                        if (grant[gi]) begin
                            state_next = ST_WAIT;
                        end
                    end
                    ST_WAIT, ST_HOLD: begin
                        if (rsp_rdy[gi]) begin
                            state_next = grant[gi] ? ST_WAIT : ST_IDLE;
                        end else begin
                            state_next = ST_HOLD;
                        end
                    end
                    default: state_next = ST_IDLE;
                endcase
            end

            // Capture read data when a WAIT response is not taken, since
            // mem_rd_data is only guaranteed for one cycle.
            always_comb begin
                hold_next = hold_reg;
                if ((state_reg == ST_WAIT) && !rsp_rdy[gi]) begin
                    hold_next = mem_rd_data;
                end
            end

            // Hold register for stalled responses.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    hold_reg <= '0;
                end else begin
                    hold_reg <= hold_next;
                end
            end

            // Outputs: response valid/data and whether the slot can take a new request.
            always_comb begin
                vld_out  = (state_reg != ST_IDLE);
                free_out = (state_reg == ST_IDLE) || rsp_rdy[gi];
                data_out = (state_reg == ST_HOLD) ? hold_reg : mem_rd_data;
            end

            assign rsp_vld[gi]   = vld_out;
            assign path_free[gi] = free_out;
            assign rsp_data[gi]  = data_out;
        end
    endgenerate

    assign p0_req_rdy  = grant[0];
    assign p1_req_rdy  = grant[1];
    assign p0_rsp_vld  = rsp_vld[0];
    assign p1_rsp_vld  = rsp_vld[1];
    assign p0_rsp_data = rsp_data[0];
    assign p1_rsp_data = rsp_data[1];

endmodule
